// File: rtl/branch_origin_detector_if.sv
// branch_origin_detector_if: issue-side pc/config inputs and per-thread branch outputs.
interface branch_origin_detector_if #(
  parameter int PC_WIDTH = 10,
  parameter int THREAD_COUNT_WIDTH = 3
);
  logic [PC_WIDTH-1:0] pc;
  logic config_wren;
  logic [THREAD_COUNT_WIDTH-1:0] config_thread;
  logic [PC_WIDTH-1:0] config_origin;
  logic [PC_WIDTH-1:0] config_destination;
  logic config_enable;
  logic branch_reached;
  logic [PC_WIDTH-1:0] branch_destination;
  logic [THREAD_COUNT_WIDTH-1:0] thread_out;
  modport master (
    output pc, config_wren, config_thread, config_origin, config_destination, config_enable,
    input branch_reached, branch_destination, thread_out
  );
  modport slave (
    input pc, config_wren, config_thread, config_origin, config_destination, config_enable,
    output branch_reached, branch_destination, thread_out
  );
endinterface

// File: rtl/branch_origin_detector.sv
// branch_origin_detector: round-robin per-thread origin-PC match with a 2-stage registered pipeline.
module branch_origin_detector #(
  parameter int PC_WIDTH = 10,
  parameter int THREAD_COUNT = 8,
  parameter int THREAD_COUNT_WIDTH = 3
) (
  input logic clk,
  input logic rst,
  branch_origin_detector_if.slave bus
);
  typedef struct packed {
    logic [PC_WIDTH-1:0] origin;
    logic [PC_WIDTH-1:0] dest;
    logic en;
  } entry_t;
  localparam logic [THREAD_COUNT_WIDTH:0] TC = (THREAD_COUNT_WIDTH+1)'(THREAD_COUNT);
  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  entry_t [THREAD_COUNT-1:0] ent_q, ent_d;
  entry_t s0_ent_q;
  logic [PC_WIDTH-1:0] s0_pc_q, dst_q;
  logic [THREAD_COUNT_WIDTH-1:0] thr_q, thr_d, s0_thr_q, thr_out_q;
  logic hit_q, wr;
  assign wr = bus.config_wren && ({1'b0, bus.config_thread} < TC);
  always_comb begin
    thr_d = (thr_q == LAST) ? '0 : thr_q + 1'b1;
    ent_d = ent_q;
    if (wr) ent_d[bus.config_thread] = '{origin: bus.config_origin, dest: bus.config_destination, en: bus.config_enable};
  end
  // stage 0 reads ent_q, so a same-edge write only shows on the thread's next pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q <= '0;
      ent_q <= '0;
      s0_ent_q <= '0;
      s0_pc_q <= '0;
      s0_thr_q <= '0;
      hit_q <= 1'b0;
      dst_q <= '0;
      thr_out_q <= '0;
    end else begin
      thr_q <= thr_d;
      ent_q <= ent_d;
      s0_ent_q <= ent_q[thr_q];
      s0_pc_q <= bus.pc;
      s0_thr_q <= thr_q;
      hit_q <= s0_ent_q.en && (s0_pc_q == s0_ent_q.origin);
      dst_q <= s0_ent_q.dest;
      thr_out_q <= s0_thr_q;
    end
  end
  assign bus.branch_reached = hit_q;
  assign bus.branch_destination = dst_q;
  assign bus.thread_out = thr_out_q;
endmodule
